// File: rtl/pc_checkpoint_buffer.sv
// Outstanding instruction-fetch tracker with a committed safe-PC checkpoint.
// On rollback it holds fetches, drains in-flight responses, then offers the checkpoint.
module pc_checkpoint_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       instr_req_i,
  input  logic                       instr_gnt_i,
  input  logic                       instr_rvalid_i,
  input  logic [31:0]                instr_addr_i,
  input  logic                       commit_i,
  input  logic                       rollback_i,
  input  logic                       restore_ack_i,
  output logic                       fetch_hold_o,
  output logic                       restore_valid_o,
  output logic [31:0]                restore_addr_o,
  output logic [31:0]                ckpt_addr_o,
  output logic [$clog2(DEPTH):0]     outstanding_o,
  output logic                       overflow_o,
  output logic                       protocol_err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, RESTORE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [31:0]     last_retired, ckpt_addr;
  logic [31:0]     pop_addr;
  logic            full, empty, push, pop_ok, push_ok;
  logic            commit_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = instr_req_i & instr_gnt_i;
  assign pop_ok  = instr_rvalid_i & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
  assign push_ok = push & (~full | pop_ok);
  assign pop_addr  = mem[rd_ptr];
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign commit_ok = commit_i & (state_q == IDLE);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= instr_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      last_retired   <= BOOT_ADDR;
      ckpt_addr      <= BOOT_ADDR;
      overflow_o     <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr       <= rd_ptr + 1'b1;
        last_retired <= pop_addr;
      end
      count <= count_nxt;
      if (push & full & ~pop_ok) overflow_o <= 1'b1;
      if (instr_rvalid_i & empty) protocol_err_o <= 1'b1;
      // Bypass the address retiring this cycle so a same-cycle commit sees it.
      if (commit_ok) ckpt_addr <= pop_ok ? pop_addr : last_retired;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rollback_i) state_d = (count_nxt != '0) ? DRAIN : RESTORE;
      DRAIN:   if (count_nxt == '0) state_d = RESTORE;
      RESTORE: if (restore_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fetch_hold_o    = (state_q != IDLE);
  assign restore_valid_o = (state_q == RESTORE);
  assign restore_addr_o  = ckpt_addr;
  assign ckpt_addr_o     = ckpt_addr;
  assign outstanding_o   = count;

endmodule

// File: tb/tb_pc_checkpoint_buffer.sv
// Directed bench for pc_checkpoint_buffer: checkpointing, drain/restore, overflow, errors, reset.
module tb_pc_checkpoint_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i = 1'b0, instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        commit_i = 1'b0, rollback_i = 1'b0, restore_ack_i = 1'b0;
  logic        fetch_hold_o, restore_valid_o, overflow_o, protocol_err_o;
  logic [31:0] restore_addr_o, ckpt_addr_o;
  logic [$clog2(DEPTH):0] outstanding_o;

  int total = 0;
  int bad   = 0;

  pc_checkpoint_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_addr_i(instr_addr_i),
    .commit_i(commit_i), .rollback_i(rollback_i), .restore_ack_i(restore_ack_i),
    .fetch_hold_o(fetch_hold_o), .restore_valid_o(restore_valid_o),
    .restore_addr_o(restore_addr_o), .ckpt_addr_o(ckpt_addr_o),
    .outstanding_o(outstanding_o), .overflow_o(overflow_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; inputs return to idle and outputs are sampled 1ns after the edge.
  task automatic cyc(input logic gnt, input logic [31:0] addr, input logic rv,
                     input logic cm, input logic rb, input logic ack);
    instr_req_i = gnt; instr_gnt_i = gnt; instr_addr_i = addr;
    instr_rvalid_i = rv; commit_i = cm; rollback_i = rb; restore_ack_i = ack;
    @(posedge clk_i); #1;
    instr_req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
    commit_i = 0; rollback_i = 0; restore_ack_i = 0;
  endtask

  initial begin
    #12;
    chk("rst_hold", 32'(fetch_hold_o), 0);
    chk("rst_rvalid", 32'(restore_valid_o), 0);
    chk("rst_out", 32'(outstanding_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_perr", 32'(protocol_err_o), 0);
    chk("rst_ckpt", ckpt_addr_o, BOOT);
    chk("rst_raddr", restore_addr_o, BOOT);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // basic checkpoint
    cyc(1, 32'h00, 0, 0, 0, 0); chk("basic_out1", 32'(outstanding_o), 1);
    cyc(1, 32'h04, 0, 0, 0, 0); chk("basic_out2", 32'(outstanding_o), 2);
    cyc(1, 32'h08, 0, 0, 0, 0); chk("basic_out3", 32'(outstanding_o), 3);
    cyc(0, 0, 1, 0, 0, 0);      chk("basic_pop1", 32'(outstanding_o), 2);
    cyc(0, 0, 1, 0, 0, 0);      chk("basic_pop2", 32'(outstanding_o), 1);
    cyc(0, 0, 1, 0, 0, 0);      chk("basic_pop3", 32'(outstanding_o), 0);
    chk("basic_ckpt_pre", ckpt_addr_o, BOOT);
    cyc(0, 0, 0, 1, 0, 0);      chk("basic_ckpt", ckpt_addr_o, 32'h08);

    // bypass commit, then a plain commit from last_retired
    cyc(1, 32'h10, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);      chk("bypass_ckpt", ckpt_addr_o, 32'h10);
    cyc(1, 32'h08, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);      chk("retired_ckpt", ckpt_addr_o, 32'h08);

    // rollback with drain; commit+rollback in DRAIN are ignored
    cyc(1, 32'h20, 0, 0, 0, 0);
    cyc(1, 32'h24, 0, 0, 0, 0); chk("rb_out2", 32'(outstanding_o), 2);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rb_hold", 32'(fetch_hold_o), 1);
    chk("rb_rv_drain", 32'(restore_valid_o), 0);
    cyc(0, 0, 1, 1, 1, 0);
    chk("drain_ckpt", ckpt_addr_o, 32'h08);
    chk("drain_rv", 32'(restore_valid_o), 0);
    chk("drain_out", 32'(outstanding_o), 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("restore_rv", 32'(restore_valid_o), 1);
    chk("restore_addr", restore_addr_o, 32'h08);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("restore_wait_rv", 32'(restore_valid_o), 1);
      chk("restore_wait_addr", restore_addr_o, 32'h08);
    end
    cyc(0, 0, 0, 0, 0, 1);
    chk("ack_rv", 32'(restore_valid_o), 0);
    chk("ack_hold", 32'(fetch_hold_o), 0);

    // empty rollback: ack with valid low ignored, 1-cycle restore
    cyc(0, 0, 0, 0, 0, 1);      chk("stray_ack_hold", 32'(fetch_hold_o), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("empty_rb_rv", 32'(restore_valid_o), 1);
    chk("empty_rb_hold", 32'(fetch_hold_o), 1);
    cyc(0, 0, 0, 0, 0, 1);      chk("empty_ack_rv", 32'(restore_valid_o), 0);

    // same-cycle commit (bypass) and rollback: restore sees new checkpoint
    cyc(1, 32'h30, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    chk("cmrb_rv", 32'(restore_valid_o), 1);
    chk("cmrb_addr", restore_addr_o, 32'h30);
    cyc(0, 0, 0, 0, 0, 1);      chk("cmrb_ack", 32'(restore_valid_o), 0);

    // full FIFO, overflow, push+pop while full with wrap
    cyc(1, 32'h40, 0, 0, 0, 0);
    cyc(1, 32'h44, 0, 0, 0, 0);
    cyc(1, 32'h48, 0, 0, 0, 0);
    cyc(1, 32'h4C, 0, 0, 0, 0); chk("full_out", 32'(outstanding_o), 4);
    chk("full_ovf_pre", 32'(overflow_o), 0);
    cyc(1, 32'h50, 0, 0, 0, 0);
    chk("ovf_out", 32'(outstanding_o), 4);
    chk("ovf_flag", 32'(overflow_o), 1);
    cyc(1, 32'h60, 1, 0, 0, 0); chk("full_pushpop_out", 32'(outstanding_o), 4);
    cyc(0, 0, 0, 1, 0, 0);      chk("full_retired", ckpt_addr_o, 32'h40);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("wrap_ckpt", ckpt_addr_o, 32'h60);
    chk("wrap_out", 32'(outstanding_o), 0);
    chk("ovf_sticky", 32'(overflow_o), 1);

    // protocol error: pop while empty
    chk("perr_pre", 32'(protocol_err_o), 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("perr_flag", 32'(protocol_err_o), 1);
    chk("perr_out", 32'(outstanding_o), 0);
    chk("perr_ckpt", ckpt_addr_o, 32'h60);
    cyc(1, 32'h64, 1, 0, 0, 0); chk("perr_push_ok", 32'(outstanding_o), 1);
    cyc(0, 0, 1, 0, 0, 0);      chk("perr_drain", 32'(outstanding_o), 0);

    // async reset while in RESTORE with tracked fetch
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h70, 0, 0, 0, 0);
    chk("pre_rst_rv", 32'(restore_valid_o), 1);
    chk("pre_rst_out", 32'(outstanding_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_rv", 32'(restore_valid_o), 0);
    chk("arst_hold", 32'(fetch_hold_o), 0);
    chk("arst_out", 32'(outstanding_o), 0);
    chk("arst_ovf", 32'(overflow_o), 0);
    chk("arst_perr", 32'(protocol_err_o), 0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_ckpt", ckpt_addr_o, BOOT);
    chk("post_rst_raddr", restore_addr_o, BOOT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
